// File: rtl/mc_control_if.sv
// Handshake bundle between the multicycle controller and its datapath/memory.
// master = controller side, slave = datapath side.
interface mc_control_if #(
  parameter int unsigned ALUOP_W = 3
);
  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic               zero;
  logic               mem_ready;
  logic               mem_req;
  logic               mem_we;
  logic               iord;
  logic               ir_write;
  logic               pc_en;
  logic [1:0]         pc_src;
  logic               reg_write;
  logic               reg_dst;
  logic               mem_to_reg;
  logic               alu_src;
  logic [ALUOP_W-1:0] alu_op;
  logic               ext_op;
  logic               jal_en;
  logic               lui_en;
  logic [2:0]         state;
  logic               illegal;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output mem_req, mem_we, iord, ir_write, pc_en, pc_src, reg_write, reg_dst,
           mem_to_reg, alu_src, alu_op, ext_op, jal_en, lui_en, state, illegal
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  mem_req, mem_we, iord, ir_write, pc_en, pc_src, reg_write, reg_dst,
           mem_to_reg, alu_src, alu_op, ext_op, jal_en, lui_en, state, illegal
  );
endinterface

// File: rtl/mc_control.sv
// Multicycle MIPS-subset control FSM with a memory not-ready watchdog and a
// sticky illegal-instruction trap.
module mc_control #(
  parameter int unsigned ALUOP_W     = 3,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset,
  mc_control_if.master bus
);

  localparam int unsigned CntW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  localparam logic [5:0] OpR     = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpSlti  = 6'h0A;
  localparam logic [5:0] OpSltiu = 6'h0B;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpXori  = 6'h0E;
  localparam logic [5:0] OpLui   = 6'h0F;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;
  localparam logic [5:0] FnJr    = 6'h08;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StTrap   = 3'd5
  } state_e;

  state_e             r_state, w_state_next;
  logic [CntW-1:0]    r_cnt, w_cnt_next, w_cnt_inc;
  logic               r_illegal;
  logic               w_timeout, w_legal, w_is_jr;

  logic [ALUOP_W-1:0] w_ex_alu_op;
  logic               w_ex_alu_src, w_ex_ext_op, w_ex_lui_en;

  logic               w_mem_req, w_mem_we, w_iord, w_ir_write, w_pc_en;
  logic [1:0]         w_pc_src;
  logic               w_reg_write, w_reg_dst, w_mem_to_reg, w_alu_src;
  logic [ALUOP_W-1:0] w_alu_op;
  logic               w_ext_op, w_jal_en, w_lui_en;

  assign w_is_jr   = (bus.opcode == OpR) && (bus.funct == FnJr);
  assign w_cnt_inc = r_cnt + CntW'(1);
  assign w_timeout = (MEM_TIMEOUT != 0) && (w_cnt_inc == CntW'(MEM_TIMEOUT));

  // ALU controls shared by EXEC and WB so the datapath sees them held.
  always_comb begin
    w_legal      = 1'b1;
    w_ex_alu_op  = ALUOP_W'(0);
    w_ex_alu_src = 1'b0;
    w_ex_ext_op  = 1'b1;
    w_ex_lui_en  = 1'b0;
    case (bus.opcode)
      OpR:                  w_ex_alu_op = ALUOP_W'(2);
      OpAndi, OpOri, OpXori: begin
        w_ex_alu_op  = ALUOP_W'(3);
        w_ex_ext_op  = 1'b0;
        w_ex_alu_src = 1'b1;
      end
      OpAddi, OpLw, OpSw:   w_ex_alu_src = 1'b1;
      OpSlti: begin
        w_ex_alu_op  = ALUOP_W'(4);
        w_ex_alu_src = 1'b1;
      end
      OpSltiu: begin
        w_ex_alu_op  = ALUOP_W'(5);
        w_ex_alu_src = 1'b1;
      end
      OpLui: begin
        w_ex_alu_src = 1'b1;
        w_ex_lui_en  = 1'b1;
      end
      OpJ, OpJal, OpBeq, OpBne: ;
      default:              w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_mem_req    = 1'b0;
    w_mem_we     = 1'b0;
    w_iord       = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_en      = 1'b0;
    w_pc_src     = 2'd0;
    w_reg_write  = 1'b0;
    w_reg_dst    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_alu_src    = 1'b0;
    w_alu_op     = ALUOP_W'(0);
    w_ext_op     = 1'b1;
    w_jal_en     = 1'b0;
    w_lui_en     = 1'b0;

    case (r_state)
      StFetch: begin
        w_mem_req = 1'b1;
        if (bus.mem_ready) begin
          w_ir_write   = 1'b1;
          w_pc_en      = 1'b1;
          w_state_next = StDecode;
        end else if (w_timeout) begin
          w_state_next = StTrap;
        end
      end
      StDecode: begin
        if (!w_legal) begin
          w_state_next = StTrap;
        end else if (bus.opcode == OpJ || bus.opcode == OpJal || w_is_jr) begin
          w_pc_en      = 1'b1;
          w_pc_src     = w_is_jr ? 2'd3 : 2'd2;
          w_reg_write  = (bus.opcode == OpJal);
          w_jal_en     = (bus.opcode == OpJal);
          w_state_next = StFetch;
        end else begin
          w_state_next = StExec;
        end
      end
      StExec: begin
        w_alu_op  = w_ex_alu_op;
        w_alu_src = w_ex_alu_src;
        w_ext_op  = w_ex_ext_op;
        w_lui_en  = w_ex_lui_en;
        case (bus.opcode)
          OpBeq, OpBne: begin
            w_alu_op     = ALUOP_W'(1);
            w_pc_src     = 2'd1;
            w_pc_en      = (bus.opcode == OpBeq) ? bus.zero : ~bus.zero;
            w_state_next = StFetch;
          end
          OpLw, OpSw: w_state_next = StMem;
          OpR, OpAddi, OpSlti, OpSltiu, OpAndi, OpOri, OpXori, OpLui:
            w_state_next = StWb;
          default:    w_state_next = StTrap;
        endcase
      end
      StMem: begin
        w_mem_req = 1'b1;
        w_iord    = 1'b1;
        w_mem_we  = (bus.opcode == OpSw);
        if (bus.mem_ready) begin
          w_state_next = (bus.opcode == OpLw) ? StWb : StFetch;
        end else if (w_timeout) begin
          w_state_next = StTrap;
        end
      end
      StWb: begin
        w_alu_op     = w_ex_alu_op;
        w_alu_src    = w_ex_alu_src;
        w_ext_op     = w_ex_ext_op;
        w_lui_en     = w_ex_lui_en;
        w_reg_write  = 1'b1;
        w_reg_dst    = (bus.opcode == OpR);
        w_mem_to_reg = (bus.opcode == OpLw);
        w_state_next = StFetch;
      end
      StTrap:  w_state_next = StTrap;
      default: w_state_next = StTrap;
    endcase

    // Reset aborts the current cycle's side effects immediately.
    if (reset) begin
      w_mem_req   = 1'b0;
      w_mem_we    = 1'b0;
      w_ir_write  = 1'b0;
      w_pc_en     = 1'b0;
      w_reg_write = 1'b0;
    end
  end

  always_comb begin
    w_cnt_next = r_cnt;
    if (w_state_next != r_state) begin
      w_cnt_next = '0;
    end else if ((r_state == StFetch || r_state == StMem) && !bus.mem_ready) begin
      w_cnt_next = w_cnt_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= StFetch;
      r_cnt     <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_illegal <= r_illegal | (w_state_next == StTrap);
    end
  end

  assign bus.mem_req    = w_mem_req;
  assign bus.mem_we     = w_mem_we;
  assign bus.iord       = w_iord;
  assign bus.ir_write   = w_ir_write;
  assign bus.pc_en      = w_pc_en;
  assign bus.pc_src     = w_pc_src;
  assign bus.reg_write  = w_reg_write;
  assign bus.reg_dst    = w_reg_dst;
  assign bus.mem_to_reg = w_mem_to_reg;
  assign bus.alu_src    = w_alu_src;
  assign bus.alu_op     = w_alu_op;
  assign bus.ext_op     = w_ext_op;
  assign bus.jal_en     = w_jal_en;
  assign bus.lui_en     = w_lui_en;
  assign bus.state      = r_state;
  assign bus.illegal    = r_illegal;

endmodule
